// File: rtl/uart_tx_fifo.sv
// rtl/uart_tx_fifo.sv - UART transmitter with integrated transmit FIFO
//
// Purpose: accepts bytes from a register-port style write interface into a
// circular FIFO. It serialises them onto tx_o as UART frames with start bit,
// DATA_BITS data bits (LSB first), optional parity and STOP_BITS stop bits.
// Frames are sent back-to-back with no idle gap while the FIFO has data.
//
// Ports:
//   clk      system clock, rising edge
//   rst      synchronous active-high reset
//   data_i   byte to transmit (bits above DATA_BITS-1 ignored)
//   valid_i  write request, accepted when valid_i && ready_o
//   ready_o  FIFO not full
//   empty_o  FIFO empty
//   count_o  FIFO occupancy 0..FIFO_DEPTH
//   busy_o   shifter active or FIFO non-empty
//   tx_o     serial line, idle high
module uart_tx_fifo #(
  parameter int CLK_FREQ   = 100000000,
  parameter int BAUD_RATE  = 115200,
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic [7:0]                         data_i,
  input  logic                               valid_i,
  output logic                               ready_o,
  output logic                               empty_o,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]    count_o,
  output logic                               busy_o,
  output logic                               tx_o
);

  localparam int BIT_PERIOD = CLK_FREQ / BAUD_RATE;
  localparam int CW         = $clog2(FIFO_DEPTH + 1);
  localparam int AW         = $clog2(FIFO_DEPTH);
  localparam int BCW        = $clog2(BIT_PERIOD);

  localparam logic [7:0]     DATA_MASK = 8'((1 << DATA_BITS) - 1);
  localparam logic [BCW-1:0] BIT_LAST  = BCW'(BIT_PERIOD - 1);
  localparam logic [3:0]     DATA_LAST = 4'(DATA_BITS - 1);
  localparam logic [3:0]     STOP_LAST = 4'(STOP_BITS - 1);
  localparam logic [CW-1:0]  FULL      = CW'(FIFO_DEPTH);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  // ---------------------------------------------------------------- FIFO
  logic [7:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic          push;
  logic          pop;
  logic [7:0]    head;
  logic          head_par;

  // ready_o comes from the registered occupancy only, so a pop on the same
  // edge never lets a write into a full FIFO.
  assign ready_o = (count != FULL);
  assign empty_o = (count == '0);
  assign count_o = count;
  assign push    = valid_i && ready_o;
  assign head    = mem[rd_ptr];
  // Entries are stored masked, so the reduction covers only the data bits.
  assign head_par = (^head) ^ (PARITY == 1);

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= data_i & DATA_MASK;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // ------------------------------------------------------------- shifter
  state_t         state, state_n;
  logic [BCW-1:0] bit_cnt, bit_cnt_n;
  logic [3:0]     bit_idx, bit_idx_n;
  logic [7:0]     shreg, shreg_n;
  logic           par_bit, par_bit_n;
  logic           tx, tx_n;
  logic           bit_done;

  assign bit_done = (bit_cnt == BIT_LAST);
  assign tx_o     = tx;
  assign busy_o   = (state != S_IDLE) || (count != '0);

  always_comb begin
    state_n   = state;
    bit_cnt_n = bit_done ? '0 : bit_cnt + 1'b1;
    bit_idx_n = bit_idx;
    shreg_n   = shreg;
    par_bit_n = par_bit;
    tx_n      = tx;
    pop       = 1'b0;

    case (state)
      S_IDLE: begin
        bit_cnt_n = '0;
        tx_n      = 1'b1;
        if (count != '0) begin
          pop       = 1'b1;
          shreg_n   = head;
          par_bit_n = head_par;
          tx_n      = 1'b0;
          state_n   = S_START;
        end
      end

      S_START: begin
        if (bit_done) begin
          tx_n      = shreg[0];
          bit_idx_n = '0;
          state_n   = S_DATA;
        end
      end

      S_DATA: begin
        if (bit_done) begin
          if (bit_idx == DATA_LAST) begin
            bit_idx_n = '0;
            if (PARITY != 0) begin
              tx_n    = par_bit;
              state_n = S_PARITY;
            end else begin
              tx_n    = 1'b1;
              state_n = S_STOP;
            end
          end else begin
            // Shift so the next bit to send is always shreg[0].
            bit_idx_n = bit_idx + 1'b1;
            shreg_n   = shreg >> 1;
            tx_n      = shreg[1];
          end
        end
      end

      S_PARITY: begin
        if (bit_done) begin
          tx_n      = 1'b1;
          bit_idx_n = '0;
          state_n   = S_STOP;
        end
      end

      S_STOP: begin
        if (bit_done) begin
          if (bit_idx == STOP_LAST) begin
            bit_idx_n = '0;
            if (count != '0) begin
              // Next frame's start bit goes out on this same edge.
              pop       = 1'b1;
              shreg_n   = head;
              par_bit_n = head_par;
              tx_n      = 1'b0;
              state_n   = S_START;
            end else begin
              tx_n    = 1'b1;
              state_n = S_IDLE;
            end
          end else begin
            bit_idx_n = bit_idx + 1'b1;
          end
        end
      end

      default: begin
        tx_n    = 1'b1;
        state_n = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= S_IDLE;
      bit_cnt <= '0;
      bit_idx <= '0;
      shreg   <= '0;
      par_bit <= 1'b0;
      tx      <= 1'b1;
    end else begin
      state   <= state_n;
      bit_cnt <= bit_cnt_n;
      bit_idx <= bit_idx_n;
      shreg   <= shreg_n;
      par_bit <= par_bit_n;
      tx      <= tx_n;
    end
  end

endmodule
